// File: rtl/uart_line_capture_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_line_capture_if
// Brief   : Serial input, byte/line status and buffer read port of uart_line_capture.
// Revision: 1.0
// ============================================================================
interface uart_line_capture_if #(
    parameter int DataBits = 8,
    parameter int BufDepth = 80
);
    logic                            rx_i;
    logic                            byte_valid_o;
    logic [DataBits-1:0]             byte_data_o;
    logic                            parity_err_o;
    logic                            frame_err_o;
    logic                            line_valid_o;
    logic [$clog2(BufDepth+1)-1:0]   line_len_o;
    logic                            line_ovf_o;
    logic                            dropped_o;
    logic [$clog2(BufDepth)-1:0]     rd_addr_i;
    logic [DataBits-1:0]             rd_data_o;
    logic                            line_ack_i;
    logic [15:0]                     stat_bytes_o;
    logic [15:0]                     stat_errs_o;

    modport master (
        output rx_i, rd_addr_i, line_ack_i,
        input  byte_valid_o, byte_data_o, parity_err_o, frame_err_o,
        input  line_valid_o, line_len_o, line_ovf_o, dropped_o,
        input  rd_data_o, stat_bytes_o, stat_errs_o
    );

    modport slave (
        input  rx_i, rd_addr_i, line_ack_i,
        output byte_valid_o, byte_data_o, parity_err_o, frame_err_o,
        output line_valid_o, line_len_o, line_ovf_o, dropped_o,
        output rd_data_o, stat_bytes_o, stat_errs_o
    );
endinterface
`default_nettype wire

// File: rtl/uart_line_capture.sv
`default_nettype none
// ============================================================================
// Module  : uart_line_capture
// Brief   : UART receiver assembling bytes into an EOL/full-terminated line
//           buffer. Optional counters: define UART_LINE_CAPTURE_STATS_EN.
// Revision: 1.0
// ============================================================================
module uart_line_capture #(
    parameter int         ClkPerBit = 16,
    parameter int         DataBits  = 8,
    parameter int         ParityEna = 0,
    parameter int         ParityOdd = 0,
    parameter int         BufDepth  = 80,
    parameter logic [7:0] EolChar   = 8'h0A
) (
    input  logic               clk_i,
    input  logic               rst_i,
    uart_line_capture_if.slave bus
);
    localparam int CntW  = $clog2(ClkPerBit);
    localparam int BitW  = $clog2(DataBits);
    localparam int LenW  = $clog2(BufDepth + 1);
    localparam int AddrW = $clog2(BufDepth);
    localparam logic [CntW-1:0]     c_half = CntW'(ClkPerBit / 2 - 1);
    localparam logic [CntW-1:0]     c_full = CntW'(ClkPerBit - 1);
    localparam logic [DataBits-1:0] c_eol  = EolChar[DataBits-1:0];

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
    } state_t;

    logic                r_rx_meta, r_rx_sync, r_rx_prev;
    state_t              r_state;
    logic [CntW-1:0]     r_cnt;
    logic [BitW-1:0]     r_bit_idx;
    logic [DataBits-1:0] r_shift;
    logic                r_par_err;
    logic                r_byte_valid, r_parity_err, r_frame_err;
    logic [DataBits-1:0] r_byte_data;
    logic                w_fall, w_tick;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= bus.rx_i;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_fall = r_rx_prev & ~r_rx_sync;
    assign w_tick = (r_cnt == '0);

    // The bit counter reloads on every sample, so timing never drifts.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_par_err    <= 1'b0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= '0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state <= ST_START;
                        r_cnt   <= c_half;
                    end
                end
                ST_START: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - CntW'(1);
                    end else if (!r_rx_sync) begin
                        r_state   <= ST_DATA;
                        r_cnt     <= c_full;
                        r_bit_idx <= '0;
                        r_par_err <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - CntW'(1);
                    end else begin
                        r_shift   <= {r_rx_sync, r_shift[DataBits-1:1]};
                        r_cnt     <= c_full;
                        r_bit_idx <= r_bit_idx + BitW'(1);
                        if (r_bit_idx == BitW'(DataBits - 1))
                            r_state <= (ParityEna != 0) ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - CntW'(1);
                    end else begin
                        r_par_err <= ((^r_shift) ^ r_rx_sync) != (ParityOdd != 0);
                        r_cnt     <= c_full;
                        r_state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - CntW'(1);
                    end else if (r_rx_sync) begin
                        r_state <= ST_IDLE;
                        if (r_par_err) begin
                            r_parity_err <= 1'b1;
                        end else begin
                            r_byte_valid <= 1'b1;
                            r_byte_data  <= r_shift;
                        end
                    end else begin
                        r_frame_err  <= 1'b1;
                        r_parity_err <= r_par_err;
                        r_state      <= ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    if (r_rx_sync)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    logic                r_line_valid, r_line_ovf, r_dropped;
    logic [LenW-1:0]     r_len;
    logic [DataBits-1:0] r_mem [BufDepth];
    logic [DataBits-1:0] r_rd_data;
    logic                w_ack, w_take, w_is_eol, w_store;
    logic [LenW-1:0]     w_len_base, w_len_next;

    // An ack in the same cycle as a byte frees the buffer before the byte lands.
    assign w_ack      = bus.line_ack_i & r_line_valid;
    assign w_len_base = w_ack ? '0 : r_len;
    assign w_len_next = w_len_base + LenW'(1);
    assign w_is_eol   = (r_byte_data == c_eol);
    assign w_take     = r_byte_valid & (~r_line_valid | w_ack);
    assign w_store    = w_take & ~w_is_eol;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_line_valid <= 1'b0;
            r_line_ovf   <= 1'b0;
            r_dropped    <= 1'b0;
            r_len        <= '0;
        end else begin
            if (w_ack) begin
                r_line_valid <= 1'b0;
                r_line_ovf   <= 1'b0;
                r_dropped    <= 1'b0;
                r_len        <= '0;
            end
            if (r_byte_valid && !w_take)
                r_dropped <= 1'b1;
            if (w_take && w_is_eol) begin
                r_line_valid <= 1'b1;
                r_line_ovf   <= 1'b0;
            end
            if (w_store) begin
                r_len <= w_len_next;
                if (w_len_next == LenW'(BufDepth)) begin
                    r_line_valid <= 1'b1;
                    r_line_ovf   <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_store)
            r_mem[w_len_base[AddrW-1:0]] <= r_byte_data;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_rd_data <= '0;
        else
            r_rd_data <= r_mem[bus.rd_addr_i];
    end

    assign bus.byte_valid_o = r_byte_valid;
    assign bus.byte_data_o  = r_byte_data;
    assign bus.parity_err_o = r_parity_err;
    assign bus.frame_err_o  = r_frame_err;
    assign bus.line_valid_o = r_line_valid;
    assign bus.line_len_o   = r_len;
    assign bus.line_ovf_o   = r_line_ovf;
    assign bus.dropped_o    = r_dropped;
    assign bus.rd_data_o    = r_rd_data;

`ifdef UART_LINE_CAPTURE_STATS_EN
    logic [15:0] r_stat_bytes, r_stat_errs;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stat_bytes <= '0;
            r_stat_errs  <= '0;
        end else begin
            if (r_byte_valid && r_stat_bytes != 16'hFFFF)
                r_stat_bytes <= r_stat_bytes + 16'd1;
            if ((r_parity_err || r_frame_err) && r_stat_errs != 16'hFFFF)
                r_stat_errs <= r_stat_errs + 16'd1;
        end
    end

    assign bus.stat_bytes_o = r_stat_bytes;
    assign bus.stat_errs_o  = r_stat_errs;
`else
    assign bus.stat_bytes_o = 16'd0;
    assign bus.stat_errs_o  = 16'd0;
`endif

endmodule
`default_nettype wire

// File: doc/uart_line_capture.md
# uart_line_capture

Parametrised UART receive-and-line-capture engine for the croc verification environment. It replaces the behavioural per-byte UART sampling and 80-character line queue with a synthesizable block. The block sits on the SoC `uart_tx_o` pin, deserialises frames of configurable width and parity, and assembles bytes into a line buffer terminated by a configurable end-of-line character or by buffer-full. Captured lines are read out through a synchronous read port and released with an acknowledge.

## Interface
- `ClkPerBit`, default 16: system clocks per UART bit. Must be at least 4.
- `DataBits`, default 8: data bits per frame, range 5..8.
- `ParityEna`, default 0: when 1, a parity bit follows the data bits.
- `ParityOdd`, default 0: when 1, odd parity; when 0, even parity. Ignored if `ParityEna`=0.
- `BufDepth`, default 80: line buffer entries, at least 2.
- `EolChar`, default 8'h0A: line terminator. It is not stored in the buffer.
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `rx_i`  in  1  serial input. Idle level is high.
- `byte_valid_o`  out  1  one-cycle pulse when a frame is accepted.
- `byte_data_o`  out  DataBits  last accepted byte. Held until the next accepted byte.
- `parity_err_o`  out  1  one-cycle pulse when a frame has a parity mismatch.
- `frame_err_o`  out  1  one-cycle pulse when the stop bit samples low.
- `line_valid_o`  out  1  a completed line is held in the buffer.
- `line_len_o`  out  $clog2(BufDepth+1)  number of stored bytes in the held line.
- `line_ovf_o`  out  1  the held line was terminated by buffer-full, not by `EolChar`.
- `dropped_o`  out  1  sticky flag: a byte was discarded while `line_valid_o`=1. Cleared by `line_ack_i`.
- `rd_addr_i`  in  $clog2(BufDepth)  buffer read index.
- `rd_data_o`  out  DataBits  registered buffer read data.
- `line_ack_i`  in  1  releases the held line.
- `stat_bytes_o`  out  16  accepted-byte counter (see Configuration).
- `stat_errs_o`  out  16  error counter (see Configuration).

## Operation
- `rx_i` passes through a 2-flop synchroniser. Both flops reset to 1.
- A falling-edge detect is applied to the synchronised signal.
- FSM states:
  - IDLE: waits for a falling edge, then goes to START.
  - START: waits `ClkPerBit/2` clocks and samples. Low goes to DATA. High is treated as a glitch and returns to IDLE with no error.
  - DATA: samples every `ClkPerBit` clocks, LSB first, for `DataBits` samples. Then goes to PARITY if `ParityEna`=1, else to STOP.
  - PARITY: takes one sample. A mismatch is latched.
  - STOP: takes one sample. High goes to IDLE. Low pulses `frame_err_o`, discards the byte, and goes to BREAK.
  - BREAK: waits for synchronised `rx_i` high, then goes to IDLE.
- Frames with a parity error pulse `parity_err_o` in the stop-sample cycle. The byte is discarded and is not counted as accepted.
- Accepted byte, when `line_valid_o`=0:
  - If the byte equals `EolChar`: the line is completed with `line_ovf_o`=0. An empty line (`line_len_o`=0) is legal and still raises `line_valid_o`.
  - Otherwise: the byte is written at index `line_len` and the length increments. When the length reaches `BufDepth`, the line is completed with `line_ovf_o`=1.
- Accepted byte, when `line_valid_o`=1: `byte_valid_o` still pulses. The byte is not stored and `dropped_o` sets.
- `line_ack_i` while `line_valid_o`=1 clears `line_valid_o`, `line_ovf_o` and `dropped_o`, and resets the length to 0. `line_ack_i` while `line_valid_o`=0 is ignored.
- If ack and an accepted byte occur in the same cycle, the ack is applied first and the byte is stored at index 0. `dropped_o` stays clear.
- `rd_addr_i` >= `line_len_o` returns don't-care data.
- Reset values:
  - All outputs reset to 0, except `byte_data_o`, which resets to 0 and is valid only after the first pulse.
  - FSM resets to IDLE, length to 0, and counters to 0.
- Reset asserted mid-frame aborts the frame. The next frame needs a fresh falling edge after reset deasserts.

## Timing
- Latency from the `rx_i` start-bit falling edge to `byte_valid_o` is 2 + `ClkPerBit/2` + (`DataBits`+`ParityEna`+1)·`ClkPerBit` + 1 clocks, ±1 clock for edge-phase uncertainty.
- `parity_err_o` and `frame_err_o` pulse in the same cycle that `byte_valid_o` would have pulsed.
- `line_valid_o` rises one clock after the terminating `byte_valid_o` pulse. `line_len_o` and `line_ovf_o` are stable while it is high.
- `rd_data_o` has a 1-clock latency from `rd_addr_i`.
- `line_valid_o` falls one clock after `line_ack_i` is sampled.
- The bit-period counter width is $clog2(`ClkPerBit`). There is no drift accumulation: the counter reloads on every sample.

## Configuration
- `UART_LINE_CAPTURE_STATS_EN` defined:
  - `stat_bytes_o` counts accepted bytes, including `EolChar` and dropped bytes.
  - `stat_errs_o` counts parity and frame errors.
  - Both counters saturate at 16'hFFFF and are cleared only by reset.
- Not defined: both ports are tied to 0 and no counter flops are instantiated.

## Test plan
- Send "Hi\n" with `ClkPerBit`=16, 8N1 -> three `byte_valid_o` pulses with data 8'h48, 8'h69, 8'h0A. Then `line_valid_o`=1, `line_len_o`=2, `line_ovf_o`=0, `rd_data_o`[0]=8'h48 and `rd_data_o`[1]=8'h69.
- Send 81 bytes of 8'h41 with no newline, `BufDepth`=80 -> `line_valid_o` with `line_len_o`=80 and `line_ovf_o`=1. The 81st byte sets `dropped_o`. `line_ack_i` clears all three flags.
- Set `ParityEna`=1, `ParityOdd`=0, and send 8'h03 with parity bit 1 -> `parity_err_o` pulses and nothing is stored. Resend with parity bit 0 -> byte stored.
- Hold the stop bit low for 3 bit periods -> one `frame_err_o` pulse. No byte is accepted until `rx_i` returns high and a new start bit arrives.
- Apply a 4-clock low glitch on idle `rx_i`, then a bare "\n" -> no error from the glitch. The "\n" produces `line_valid_o`=1 with `line_len_o`=0.
- Assert `rst_i` mid-data-bit, release it, then send 8'h55 -> all outputs read 0 during reset. One clean 8'h55 is accepted afterwards, and with the macro defined `stat_bytes_o`=1.
